// File: rtl/elementary_ca.sv
// ---------------------------------------------------------------------------
// elementary_ca
//   One-dimensional, two-state, radius-1 cellular automaton (Wolfram
//   elementary rules).  The cells are loaded and read in BLOCK_W-wide blocks.
//   A small IDLE/RUN/DONE controller advances the whole array one generation
//   per cycle, either on single steps or in a free run with an optional
//   generation limit.
//
//   Optional feature macro: ECA_STABLE_DETECT_EN
//     defined   : stable = (next generation == current generation).  A RUN
//                 cycle that sees stable=1 goes to DONE without advancing.
//     undefined : stable is tied low and no comparator is built.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   reset      in   asynchronous active-high reset
//   rule_we    in   load rule_in into the rule register
//   rule_in    in   [7:0] Wolfram rule number
//   wrap       in   1 = toroidal boundary, 0 = zero-padded boundary
//   wr_en      in   write wr_data into block addr (beats an advance)
//   addr       in   [ADDR_W-1:0] block address for read and write
//   wr_data    in   [BLOCK_W-1:0] bit k -> cell addr*BLOCK_W+k
//   rd_data    out  [BLOCK_W-1:0] current cells of block addr (0 if out of range)
//   run        in   level: free-run request
//   step       in   pulse: advance one generation while IDLE
//   gen_limit  in   [GEN_W-1:0] generations per run, 0 = unlimited
//   gen_count  out  [GEN_W-1:0] generations advanced since reset (wraps)
//   busy       out  high in RUN
//   done       out  high in DONE
//   stable     out  next generation equals current (macro dependent)
// ---------------------------------------------------------------------------
module elementary_ca #(
    parameter int         NUM_CELLS    = 64,
    parameter int         BLOCK_W      = 8,
    parameter int         GEN_W        = 16,
    parameter logic [7:0] DEFAULT_RULE = 8'd110,
    localparam int        NUM_BLOCKS   = NUM_CELLS / BLOCK_W,
    localparam int        ADDR_W       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rule_we,
    input  logic [7:0]         rule_in,
    input  logic               wrap,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BLOCK_W-1:0] wr_data,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               run,
    input  logic               step,
    input  logic [GEN_W-1:0]   gen_limit,
    output logic [GEN_W-1:0]   gen_count,
    output logic               busy,
    output logic               done,
    output logic               stable
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NUM_CELLS-1:0] cells_q, cells_d;
    logic [7:0]           rule_q;
    logic [GEN_W-1:0]     gen_q, gen_d;
    logic [GEN_W-1:0]     target_q, target_d;
    logic                 unlim_q, unlim_d;

    logic [NUM_CELLS+1:0] ext_cells;
    logic [NUM_CELLS-1:0] next_gen;
    logic [NUM_CELLS-1:0] wr_merge;
    logic                 advance;
    logic                 stable_hit;

    // Neighbourhood vector: bit 0 is c[-1], bit NUM_CELLS+1 is c[NUM_CELLS].
    // The pad cells follow the wrap input live, so it is sampled per advance.
    assign ext_cells = {wrap & cells_q[0], cells_q, wrap & cells_q[NUM_CELLS-1]};

    // Rule lookup: ext_cells[i +: 3] is {c[i+1], c[i], c[i-1]}.
    always_comb begin
        next_gen = {NUM_CELLS{1'b0}};
        for (int i = 0; i < NUM_CELLS; i++) begin
            next_gen[i] = rule_q[ext_cells[i +: 3]];
        end
    end

    // Block read mux and block write merge; unmatched addresses read 0 and write nothing.
    always_comb begin
        rd_data  = {BLOCK_W{1'b0}};
        wr_merge = cells_q;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (addr == ADDR_W'(b)) begin
                rd_data                        = cells_q[b*BLOCK_W +: BLOCK_W];
                wr_merge[b*BLOCK_W +: BLOCK_W] = wr_data;
            end else begin
                wr_merge[b*BLOCK_W +: BLOCK_W] = cells_q[b*BLOCK_W +: BLOCK_W];
            end
        end
    end

`ifdef ECA_STABLE_DETECT_EN
    assign stable_hit = (next_gen == cells_q);
`else
    assign stable_hit = 1'b0;
`endif

    // Controller: decides the advance and the next state; a write always wins over an advance.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unlim_d  = unlim_q;
        advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    // Entering RUN: freeze the stop point so later gen_limit changes are ignored.
                    state_d  = ST_RUN;
                    target_d = gen_q + gen_limit;
                    unlim_d  = (gen_limit == {GEN_W{1'b0}});
                end else if (step && !wr_en) begin
                    advance = 1'b1;
                end else begin
                    advance = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (wr_en) begin
                    advance = 1'b0;
                end else if (stable_hit) begin
                    state_d = ST_DONE;
                end else begin
                    advance = 1'b1;
                    if (!unlim_q && ((gen_q + GEN_W'(1)) == target_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en) begin
            cells_d = wr_merge;
            gen_d   = gen_q;
        end else if (advance) begin
            cells_d = next_gen;
            gen_d   = gen_q + GEN_W'(1);
        end else begin
            cells_d = cells_q;
            gen_d   = gen_q;
        end
    end

    // State registers with asynchronous reset to the single-seed pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cells_q  <= NUM_CELLS'(1);
            rule_q   <= DEFAULT_RULE;
            gen_q    <= {GEN_W{1'b0}};
            target_q <= {GEN_W{1'b0}};
            unlim_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            gen_q    <= gen_d;
            target_q <= target_d;
            unlim_q  <= unlim_d;
            // The advance in this same cycle still used the old rule.
            if (rule_we) begin
                rule_q <= rule_in;
            end else begin
                rule_q <= rule_q;
            end
        end
    end

    assign gen_count = gen_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign stable    = stable_hit;

endmodule
